// File: rtl/seq_hit_logger.sv
// rtl/seq_hit_logger.sv - hit counter and inter-hit gap recorder with record FIFO (optional macro SEQ_HIT_GAP_CHECK_EN)
module seq_hit_logger #(
    parameter int GAP_W   = 8,
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic             clr,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [GAP_W-1:0] rec_gap,
    output logic             rec_sat,
    output logic [CNT_W-1:0] hit_count,
    output logic             ovf,
    output logic             gap_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Reject parameter sets the FIFO pointer wrap and gap check cannot honour
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("seq_hit_logger: DEPTH must be a power of two and at least 2");
    end
    if ((MIN_GAP < 0) || (MIN_GAP > (2**GAP_W - 1))) begin : g_bad_min_gap
        $error("seq_hit_logger: MIN_GAP must fit in GAP_W bits");
    end

    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] mem_gap [DEPTH];
    logic             mem_sat [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      occ;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic gap_is_sat;

    assign full       = (occ == OCC_FULL);
    assign rec_valid  = (occ != '0);
    assign pop        = rec_valid && rec_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push       = hit && (!full || pop);
    assign drop       = hit && full && !pop;
    assign gap_is_sat = (gap_cnt == GAP_MAX);

    assign rec_gap = rec_valid ? mem_gap[rptr] : '0;
    assign rec_sat = rec_valid ? mem_sat[rptr] : 1'b0;

    // Cycles since the previous hit (or since reset release), saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (hit) begin
            gap_cnt <= GAP_W'(1);
        end else if (!gap_is_sat) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Record storage; stale entries are masked by rec_valid so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_gap[wptr] <= gap_cnt;
            mem_sat[wptr] <= gap_is_sat;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Saturating hit counter and sticky overflow; clr keeps only this cycle's events
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            hit_count <= CNT_W'(hit);
            ovf       <= drop;
        end else begin
            if (hit && (hit_count != CNT_MAX)) hit_count <= hit_count + 1'b1;
            ovf <= ovf | drop;
        end
    end

`ifdef SEQ_HIT_GAP_CHECK_EN
    logic first_seen;
    logic gap_short;

    // The first hit after reset measures time since reset, not a real gap
    assign gap_short = hit && first_seen && (gap_cnt < GAP_W'(MIN_GAP));

    // Sticky too-short-gap flag
    always_ff @(posedge clk) begin
        if (reset) begin
            first_seen <= 1'b0;
            gap_err    <= 1'b0;
        end else begin
            if (hit) first_seen <= 1'b1;
            if (clr) gap_err <= gap_short;
            else     gap_err <= gap_err | gap_short;
        end
    end
`else
    assign gap_err = 1'b0;
`endif

endmodule

// File: doc/seq_hit_logger.md
# seq_hit_logger

Downstream consumer of the 1001 overlapping Mealy detector output. Samples the detector's one-cycle `out` pulse every clock and counts hits. For each hit it measures the gap in cycles since the previous hit and queues that gap in a small FIFO. Software or a downstream stage drains the FIFO over a valid/ready handshake.

## Interface
Parameters:
- `GAP_W`, default 8: gap measurement width; gap saturates at 2^GAP_W-1.
- `CNT_W`, default 16: total hit counter width; saturating.
- `DEPTH`, default 4: record FIFO depth; power of 2, ≥2.
- `MIN_GAP`, default 3: smallest legal gap for a 4-bit overlapping pattern; used only by the optional check.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high; clears all state.
- `hit` input 1: detector `out`; one hit per cycle it is high.
- `clr` input 1: synchronous clear of `hit_count`, `ovf`, `gap_err`; FIFO untouched.
- `rec_valid` output 1: FIFO non-empty.
- `rec_ready` input 1: consumer accepts head record when `rec_valid` is also high.
- `rec_gap` output GAP_W: gap of head record; 0 when empty.
- `rec_sat` output 1: head record's gap saturated.
- `hit_count` output CNT_W: total hits, saturating at all-ones.
- `ovf` output 1: sticky; a hit was dropped because the FIFO was full.
- `gap_err` output 1: sticky gap violation; see Configuration.

## Operation
- **Gap counter `gap_cnt`** (GAP_W bits, internal):
  - Reset value 0.
  - On a `hit` cycle it becomes 1.
  - Otherwise it increments, saturating at max.
- **Record on each hit:**
  - `gap` = current `gap_cnt` (value before update).
  - `sat` = (`gap_cnt` == max).
  - First hit after reset records cycles elapsed since reset release. The first post-reset cycle is index 0.
- **FIFO:** DEPTH entries, read/write pointers with wrap-around, occupancy count 0..DEPTH.
  - Push on `hit`. Pop on `rec_valid && rec_ready`.
  - Full with push and pop in the same cycle: both occur, occupancy unchanged, no drop.
  - Full with push and no pop: record dropped, `ovf` set. FIFO contents unchanged.
  - Empty: a pop cannot occur, since `rec_valid` is 0.
- **`hit_count`:** +1 per hit, saturating.
  - `clr` and `hit` in the same cycle: `hit_count` becomes 1, `ovf` and `gap_err` take the value from this cycle's events only.
- **`reset` mid-operation:** FIFO emptied and pointers zeroed; records in flight are lost; `gap_cnt` returns to 0.
- **Reset values:**
  - `rec_valid` 0, `rec_gap` 0, `rec_sat` 0.
  - `hit_count` 0, `ovf` 0, `gap_err` 0.

## Timing
- All outputs are registered or decoded directly from registered FIFO state. There is no combinational path from `hit` to any output.
- **Latency:**
  - `hit` at cycle N gives `rec_valid` = 1 at cycle N+1 when the FIFO was empty.
  - `hit_count` updated at N+1.
  - `ovf` and `gap_err` set visible at N+1.
- `rec_ready` is sampled at posedge. The head advances one cycle after acceptance, and the next record appears the same cycle.
- Throughput: one push and one pop per cycle sustained.
- `rec_gap` and `rec_sat` are stable while `rec_valid && !rec_ready`.

## Configuration
- **Macro `SEQ_HIT_GAP_CHECK_EN`**
  - **Defined:**
    - `gap_err` is set on any hit whose recorded gap < MIN_GAP, excluding the first hit after reset.
    - `gap_err` is sticky until `clr` or `reset`.
    - The offending record is still pushed normally.
  - **Undefined:**
    - Check logic is not compiled.
    - `gap_err` is tied to 0.
    - All other behaviour is identical.

## Test plan
- **Reset state:** assert `reset` 2 cycles.
  - Required: all outputs 0.
  - Hold `reset` high with `hit` = 1: still all 0.
- **Overlapping stream:** release reset, drive `hit` high at cycles 3, 6, 10, `rec_ready` = 1.
  - Required: records gap 3, 3, 4, each valid at hit+1.
  - `hit_count` = 3, `ovf` = 0.
- **Overflow:** `rec_ready` = 0, DEPTH=4, hits at cycles 3, 6, 9, 12, 15.
  - Required: 4 records (3, 3, 3, 3) retained, 5th dropped.
  - `ovf` = 1 from cycle 16, `hit_count` = 5.
  - Draining yields exactly 4 records.
- **Full push+pop:** FIFO full, `rec_ready` = 1 and `hit` = 1 in the same cycle.
  - Required: no drop, `ovf` stays 0.
  - Occupancy remains 4, new gap appears at tail.
- **Saturation and clr:** GAP_W=4, no hit for 20 cycles, then `hit`.
  - Required: record gap 15, `rec_sat` = 1.
  - `clr` coincident with a hit: `hit_count` = 1, `ovf` = 0.
- **Gap check (`SEQ_HIT_GAP_CHECK_EN` defined):** hits at cycles 3 and 5.
  - Required: second record gap 2, `gap_err` = 1 at cycle 6 until `clr`.
  - Macro undefined: `gap_err` stays 0.
